// File: rtl/dm_responder_pkg.sv
// Shared CPU memory-map constants and data-memory trace types.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package dm_responder_pkg;

  // Data memory map: word 0 sits at DM_ADDR_BASE, DM_DEPTH_WORDS words deep.
  localparam int unsigned DM_DEPTH_WORDS = 4096;
  localparam logic [31:0] DM_ADDR_BASE   = 32'h0000_0000;

  // One reported write: who issued it, which word, and the word afterwards.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_t;

  // Byte address of the word containing a.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// CPU data-port bus plus the write-trace and error observation outputs.
// Latency: n/a (wiring only).
// Backpressure: none; every access completes in its own cycle.
interface dm_responder_if;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic        err;
  logic [31:0] err_addr;

  // CPU side: issues accesses, observes read data, trace and error.
  modport master (
    output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr,
    input  m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data,
    input  err, err_addr
  );

  // Memory side.
  modport slave (
    input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr,
    output m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data,
    output err, err_addr
  );
endinterface

// File: rtl/dm_byte_merge.sv
// Merges store data into an existing word lane by lane.
// Latency: combinational.
// Backpressure: none.
module dm_byte_merge (
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  byteen_i,
  output logic [31:0] new_o
);

  // Each enabled lane takes the store byte; disabled lanes keep the old byte.
  always_comb begin
    new_o = old_i;
    for (int i = 0; i < 4; i++) begin
      if (byteen_i[i]) new_o[8*i +: 8] = wdata_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/dm_responder.sv
// CPU data memory: zero-latency reads, byte-lane writes, write trace, sticky range error.
// Latency: read combinational; write committed on the edge, traced the cycle after.
// Backpressure: none; one access per cycle always accepted.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DM_DEPTH_WORDS,
  parameter logic [31:0] ADDR_BASE   = DM_ADDR_BASE
) (
  input  logic         clk,
  input  logic         reset,
  dm_responder_if.slave bus
);

  localparam int          IDXW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] BYTE_SPAN = 33'(DEPTH_WORDS) << 2;

  logic [31:0]     mem_q [DEPTH_WORDS];
  logic [31:0]     off;
  logic            in_range;
  logic [IDXW-1:0] idx;
  logic [31:0]     old_word;
  logic [31:0]     merged;
  logic            wr_en;
  logic            err_hit;

  logic            trace_vld_q, trace_vld_d;
  trace_t          trace_q, trace_d;
  logic            err_q, err_d;
  logic [31:0]     err_addr_q, err_addr_d;
  logic [31:0]     prev_addr_q;
  logic            prev_vld_q;

  // Offset compare in 33 bits so a range ending at 2^32 cannot wrap.
  assign off      = bus.m_data_addr - ADDR_BASE;
  assign in_range = (bus.m_data_addr >= ADDR_BASE) && ({1'b0, off} < BYTE_SPAN);
  assign idx      = off[IDXW+1:2];
  assign old_word = mem_q[idx];
  assign wr_en    = in_range && (bus.m_data_byteen != 4'b0000);

  // Reads of a word being written this cycle see the pre-write contents.
  assign bus.m_data_rdata = in_range ? old_word : 32'h0000_0000;

  // A held read address only reports once; a write always reports.
  assign err_hit = !in_range &&
                   ((bus.m_data_byteen != 4'b0000) || !prev_vld_q ||
                    (bus.m_data_addr != prev_addr_q));

  dm_byte_merge u_merge (
    .old_i   (old_word),
    .wdata_i (bus.m_data_wdata),
    .byteen_i(bus.m_data_byteen),
    .new_o   (merged)
  );

  // Next-state for the trace and error registers.
  always_comb begin
    trace_vld_d = 1'b0;
    trace_d     = trace_q;
    err_d       = err_q;
    err_addr_d  = err_addr_q;
    if (wr_en) begin
      trace_vld_d  = 1'b1;
      trace_d.pc   = bus.m_inst_addr;
      trace_d.addr = word_align(bus.m_data_addr);
      trace_d.data = merged;
    end
    if (err_hit && !err_q) begin
      err_d      = 1'b1;
      err_addr_d = bus.m_data_addr;
    end
  end

  // Memory array; reset wipes every word so a pending write is discarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) mem_q[i] <= 32'h0000_0000;
    end else if (wr_en) begin
      mem_q[idx] <= merged;
    end
  end

  // Trace, error and previous-address registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trace_vld_q <= 1'b0;
      trace_q     <= '0;
      err_q       <= 1'b0;
      err_addr_q  <= 32'h0000_0000;
      prev_addr_q <= 32'h0000_0000;
      prev_vld_q  <= 1'b0;
    end else begin
      trace_vld_q <= trace_vld_d;
      trace_q     <= trace_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
      prev_addr_q <= bus.m_data_addr;
      prev_vld_q  <= 1'b1;
    end
  end

  assign bus.trace_valid = trace_vld_q;
  assign bus.trace_pc    = trace_q.pc;
  assign bus.trace_addr  = trace_q.addr;
  assign bus.trace_data  = trace_q.data;
  assign bus.err         = err_q;
  assign bus.err_addr    = err_addr_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed plus randomized bench for dm_responder against a word-array model.
// Latency: one access per clock; trace checked just after each edge.
// Backpressure: none.
module tb_dm_responder;
  localparam int unsigned DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  dm_responder_if bus();

  dm_responder #(.DEPTH_WORDS(DEPTH), .ADDR_BASE(BASE)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state, in terms of the rules the memory must obey.
  logic [31:0] m_mem [DEPTH];
  logic        m_tv;
  logic [31:0] m_tpc, m_taddr, m_tdata;
  logic        m_err;
  logic [31:0] m_err_addr;
  logic        m_prev_vld;
  logic [31:0] m_prev_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_in_range(input logic [31:0] a);
    longint la = longint'(a);
    return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * longint'(DEPTH));
  endfunction

  function automatic int m_index(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!m_in_range(a)) return 32'h0;
    return m_mem[m_index(a)];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 32'h0;
    m_tv = 1'b0; m_tpc = 32'h0; m_taddr = 32'h0; m_tdata = 32'h0;
    m_err = 1'b0; m_err_addr = 32'h0;
    m_prev_vld = 1'b0; m_prev_addr = 32'h0;
  endtask

  // Effect of one rising edge on the reference.
  task automatic m_edge(input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] pc);
    logic [31:0] w;
    bit ok = m_in_range(a);
    m_tv = 1'b0;
    if (ok && be != 4'b0) begin
      w = m_mem[m_index(a)];
      for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
      m_mem[m_index(a)] = w;
      m_tv = 1'b1; m_tpc = pc; m_taddr = a & 32'hFFFF_FFFC; m_tdata = w;
    end
    if (!ok && !m_err && (be != 4'b0 || !m_prev_vld || a != m_prev_addr)) begin
      m_err = 1'b1; m_err_addr = a;
    end
    m_prev_vld = 1'b1; m_prev_addr = a;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".trace_valid"}, 32'(bus.trace_valid), 32'(m_tv));
    chk({tag, ".trace_pc"},    bus.trace_pc,    m_tpc);
    chk({tag, ".trace_addr"},  bus.trace_addr,  m_taddr);
    chk({tag, ".trace_data"},  bus.trace_data,  m_tdata);
    chk({tag, ".err"},         32'(bus.err),    32'(m_err));
    chk({tag, ".err_addr"},    bus.err_addr,    m_err_addr);
  endtask

  // One access: drive after the falling edge, check read data, then check the edge result.
  task automatic step(input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input logic [31:0] pc);
    @(negedge clk);
    bus.m_data_addr = a; bus.m_data_wdata = wd;
    bus.m_data_byteen = be; bus.m_inst_addr = pc;
    #1;
    chk("rdata", bus.m_data_rdata, m_read(a));
    m_edge(a, wd, be, pc);
    @(posedge clk);
    #1;
    chk_outputs("step");
  endtask

  task automatic rand_phase(input int n);
    logic [31:0] a;
    logic [3:0]  be;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 19) == 0)
        a = 32'h4000 + ($urandom % 32'hFFFF_C000);
      else
        a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      be = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      step(a, $urandom, be, 32'h0000_1000 + 32'(k) * 4);
    end
  endtask

  initial begin
    m_clear();
    bus.m_data_addr = 32'h10; bus.m_data_wdata = 32'hDEAD_BEEF;
    bus.m_data_byteen = 4'b1111; bus.m_inst_addr = 32'h100;

    // Reset state, with a write presented during reset.
    #2;
    chk("reset.rdata", bus.m_data_rdata, 32'h0);
    chk_outputs("reset");
    @(posedge clk); #1;
    chk_outputs("reset_edge");
    @(negedge clk);
    bus.m_data_byteen = 4'b0000;
    reset = 1'b1;

    // Full-word write then read back.
    step(32'h10, 32'h1234_5678, 4'b1111, 32'h200);
    chk("w10.trace_data", bus.trace_data, 32'h1234_5678);
    chk("w10.trace_addr", bus.trace_addr, 32'h10);
    step(32'h10, 32'h0, 4'b0000, 32'h204);
    chk("r10.trace_valid", 32'(bus.trace_valid), 32'h0);
    step(32'h10, 32'h0, 4'b0000, 32'h208);

    // Single-lane write at an unaligned byte address.
    step(32'h11, 32'h0000_AB00, 4'b0010, 32'h20C);
    chk("w11.trace_data", bus.trace_data, 32'h1234_AB78);
    chk("w11.trace_addr", bus.trace_addr, 32'h10);

    // Same-cycle write and read: old data now, new data next cycle.
    step(32'h20, 32'hFFFF_FFFF, 4'b1111, 32'h210);
    step(32'h20, 32'h0, 4'b0000, 32'h214);
    chk("r20.rdata_held", bus.m_data_rdata, 32'hFFFF_FFFF);

    // Back-to-back writes, then a non-contiguous lane pattern.
    step(32'h0, 32'hA0A0_A0A0, 4'b1111, 32'h300);
    step(32'h4, 32'hB1B1_B1B1, 4'b1111, 32'h304);
    step(32'h8, 32'hC2C2_C2C2, 4'b1111, 32'h308);
    step(32'h8, 32'h1122_3344, 4'b0101, 32'h30C);
    chk("w8.lanes", bus.trace_data, 32'hC222_C244);

    // Range boundary: last word in range, then first word beyond.
    step(32'h3FFC, 32'h5555_AAAA, 4'b1111, 32'h400);
    step(32'h4000, 32'h7777_7777, 4'b1111, 32'h404);
    chk("oor.err_addr", bus.err_addr, 32'h4000);
    step(32'h5000, 32'h0, 4'b0000, 32'h408);
    step(32'h5000, 32'h0, 4'b1111, 32'h40C);
    chk("oor2.err_addr", bus.err_addr, 32'h4000);

    rand_phase(300);

    // Reset mid-sequence with a write pending.
    @(negedge clk);
    bus.m_data_addr = 32'h10; bus.m_data_wdata = 32'h9999_9999;
    bus.m_data_byteen = 4'b1111; bus.m_inst_addr = 32'h500;
    #2;
    reset = 1'b0;
    #1;
    m_clear();
    chk("midrst.rdata", bus.m_data_rdata, 32'h0);
    chk_outputs("midrst");
    @(posedge clk); #1;
    chk_outputs("midrst_edge");
    @(negedge clk);
    bus.m_data_byteen = 4'b0000;
    reset = 1'b1;
    step(32'h10, 32'h0, 4'b0000, 32'h504);
    step(32'h8, 32'h0, 4'b0000, 32'h508);

    // Error capture works again after reset.
    step(32'h8000, 32'h0, 4'b0000, 32'h50C);
    chk("rerr.err_addr", bus.err_addr, 32'h8000);
    rand_phase(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096, number of 32-bit words in the data memory (byte range 0x0000_0000 to 4*DEPTH_WORDS-1).
REQ-002 Parameter ADDR_BASE, default 32'h0000_0000, byte address of word 0.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 m_data_addr  input  32  byte address of the CPU data access.
REQ-006 m_data_wdata  input  32  store data, already lane-aligned by the CPU.
REQ-007 m_data_byteen  input  4  byte-lane write enables; 4'b0000 = read or no access.
REQ-008 m_inst_addr  input  32  PC of the M-stage instruction issuing the access.
REQ-009 m_data_rdata  output  32  full aligned word at m_data_addr.
REQ-010 trace_valid  output  1  one-cycle pulse: a committed write is reported.
REQ-011 trace_pc  output  32  PC of the reported write.
REQ-012 trace_addr  output  32  word-aligned byte address of the reported write.
REQ-013 trace_data  output  32  full word contents after the write was merged.
REQ-014 err  output  1  sticky: an access fell outside the memory range.
REQ-015 err_addr  output  32  m_data_addr of the first out-of-range access.

Function
REQ-016 Word index = (m_data_addr - ADDR_BASE) >> 2; bits [1:0] SHALL be ignored for indexing.
REQ-017 In range iff ADDR_BASE <= m_data_addr < ADDR_BASE + 4*DEPTH_WORDS (unsigned compare, no wrap).
REQ-018 m_data_rdata SHALL be combinational from the array (zero-latency read); out of range -> 32'h0000_0000.
REQ-019 Write when m_data_byteen != 0 and in range: on the rising edge, byte lane i (bits 8i+7:8i) updated from m_data_wdata iff byteen[i]; other lanes kept.
REQ-020 Read in the same cycle as a write to the same word SHALL return the pre-write contents.
REQ-021 Per accepted write, the cycle after the write edge: trace_valid=1, trace_pc=m_inst_addr, trace_addr={addr[31:2],2'b00}, trace_data=merged word; otherwise trace_valid=0, other trace outputs hold.
REQ-022 Back-to-back writes SHALL produce back-to-back trace pulses, none dropped or merged.
REQ-023 Out-of-range write: array unchanged, no trace pulse.
REQ-024 Any out-of-range access (read address with byteen=0 counts only when addr differs from previous cycle's addr, writes always) while err=0 SHALL set err=1 and capture err_addr on that edge; subsequent errors SHALL NOT update err_addr.
REQ-025 Misaligned byteen patterns (e.g. 4'b0101) SHALL be applied lane-wise without error.

Reset
REQ-026 reset=0 SHALL immediately clear all array words to 0, trace_valid=0, trace_pc/trace_addr/trace_data=0, err=0, err_addr=0.
REQ-027 A write coincident with reset assertion SHALL be discarded; no trace pulse after release for it.
REQ-028 First write accepted on the first rising edge with reset=1.

Structure
REQ-029 DEPTH_WORDS default and ADDR_BASE default SHALL live in the shared CPU package beside the other memory-map constants.
REQ-030 One sub-module, dm_byte_merge (combinational old word + wdata + byteen -> new word), SHALL be shared by write path and trace_data.

Verification
REQ-031 Write 0x12345678 byteen 4'b1111 to 0x10, then read 0x10 -> rdata 0x12345678; trace pulse pc/addr 0x10/data 0x12345678.
REQ-032 After REQ-031, write 0x0000AB00 byteen 4'b0010 to 0x11 -> word 0x1234AB78, trace_addr 0x10.
REQ-033 Same-cycle write 0xFFFFFFFF and read at 0x20 (was 0) -> rdata 0 that cycle, 0xFFFFFFFF next.
REQ-034 Write to 0x4000 (DEPTH 4096) -> no trace, err=1, err_addr 0x4000; later access 0x5000 leaves err_addr 0x4000.
REQ-035 Three consecutive writes to 0x0,0x4,0x8 -> three consecutive trace pulses in order.
REQ-036 Assert reset mid-sequence with write pending -> all outputs 0 asynchronously, array reads 0, no trace after release.
